// File: rtl/e203_exu_flush_arb.sv
// EXU flush arbiter: picks exception/IRQ over branch-mispredict flush,
// registers the target PC, holds it for the IFU and then enforces a hold-off.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   excp_flush_req/_add_op1/_add_op2     exception/IRQ flush source
//   excp_flush_ack                       exception accepted (comb, IDLE only)
//   brchmis_flush_req/_add_op1/_add_op2  branch-mispredict flush source
//   brchmis_flush_ack                    branch accepted (comb, IDLE only)
//   pipe_flush_req/_pc/_src              registered flush toward IFU
//   pipe_flush_ack                       IFU accepts the flush
//   flush_busy                           arbiter not idle
//   excp_flush_cnt, brchmis_flush_cnt    saturating handshake counters,
//                                        only with E203_FLUSH_ARB_PERF_CNT_EN
module e203_exu_flush_arb #(
  parameter int PC_SIZE = 32,
  parameter int HOLDOFF = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               excp_flush_req,
  input  logic [PC_SIZE-1:0] excp_flush_add_op1,
  input  logic [PC_SIZE-1:0] excp_flush_add_op2,
  output logic               excp_flush_ack,
  input  logic               brchmis_flush_req,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op1,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op2,
  output logic               brchmis_flush_ack,
  output logic               pipe_flush_req,
  output logic [PC_SIZE-1:0] pipe_flush_pc,
  output logic               pipe_flush_src,
  input  logic               pipe_flush_ack,
  output logic               flush_busy
`ifdef E203_FLUSH_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        excp_flush_cnt,
  output logic [31:0]        brchmis_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [2:0] HOLD_INIT = 3'(HOLDOFF);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               src_q, src_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    pc_d              = pc_q;
    src_d             = src_q;
    excp_flush_ack    = 1'b0;
    brchmis_flush_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Acks are masked during reset: the state already reads IDLE then.
        if (!rst && excp_flush_req) begin
          excp_flush_ack = 1'b1;
          pc_d    = excp_flush_add_op1 + excp_flush_add_op2;
          src_d   = 1'b1;
          state_d = PEND;
        end else if (!rst && brchmis_flush_req) begin
          brchmis_flush_ack = 1'b1;
          pc_d    = brchmis_flush_add_op1 + brchmis_flush_add_op2;
          src_d   = 1'b0;
          state_d = PEND;
        end
      end
      PEND: begin
        if (pipe_flush_ack) begin
          if (HOLDOFF == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = HOLD_INIT;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 3'd1;
        // Leave on the count of 1 so HOLD spans exactly HOLDOFF cycles.
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pipe_flush_req = (state_q == PEND);
  assign pipe_flush_pc  = pc_q;
  assign pipe_flush_src = src_q;
  assign flush_busy     = (state_q != IDLE);

`ifdef E203_FLUSH_ARB_PERF_CNT_EN
  logic        hs;
  logic [31:0] excp_cnt_q, excp_cnt_d;
  logic [31:0] brchmis_cnt_q, brchmis_cnt_d;

  assign hs = (state_q == PEND) && pipe_flush_ack;

  always_comb begin
    excp_cnt_d    = excp_cnt_q;
    brchmis_cnt_d = brchmis_cnt_q;
    if (hs && src_q && (excp_cnt_q != 32'hFFFF_FFFF)) begin
      excp_cnt_d = excp_cnt_q + 32'd1;
    end
    if (hs && !src_q && (brchmis_cnt_q != 32'hFFFF_FFFF)) begin
      brchmis_cnt_d = brchmis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_cnt_q    <= '0;
      brchmis_cnt_q <= '0;
    end else begin
      excp_cnt_q    <= excp_cnt_d;
      brchmis_cnt_q <= brchmis_cnt_d;
    end
  end

  assign excp_flush_cnt    = excp_cnt_q;
  assign brchmis_flush_cnt = brchmis_cnt_q;
`endif

endmodule
